// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid_checker (master) and the
// system ID slave. Only the signals needed for a two-word read are carried.
//   avm_address     : word address (0 = ID, 1 = timestamp)
//   avm_read        : read strobe
//   avm_readdata    : read data, valid when avm_read=1 and avm_waitrequest=0
//   avm_waitrequest : slave/fabric stall
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/sysid_checker.sv
// sysid_checker: reads the system ID (word 0) and build timestamp (word 1)
// from the ID slave, compares them against expected values and reports the
// result to boot/status logic. Runs once after reset (AUTO_START) and again
// on each start pulse received while not busy.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   start            : one-cycle request for a new check (ignored while busy)
//   avm              : Avalon-MM master side of the bus to the ID slave
//   busy             : read sequence in progress
//   done             : sticky, result fields valid
//   id_match/ts_match: captured word equals its expected value
//   timeout          : a read stalled for TIMEOUT_CYCLES cycles
//   id_value/ts_value: captured words
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1435703700,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  sysid_checker_if.master        avm,
  output logic                   busy,
  output logic                   done,
  output logic                   id_match,
  output logic                   ts_match,
  output logic                   timeout,
  output logic [31:0]            id_value,
  output logic [31:0]            ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_e;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;       // queued request: auto-start or start seen in FINISH
  logic [15:0] cnt_q, cnt_d;         // stalled cycles of the current read
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        idm_q, idm_d;
  logic        tsm_q, tsm_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= AUTO_START;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idm_q   <= 1'b0;
      tsm_q   <= 1'b0;
      tmo_q   <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idm_q   <= idm_d;
      tsm_q   <= tsm_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    idm_d   = idm_q;
    tsm_d   = tsm_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    ts_d    = ts_q;

    case (state_q)
      IDLE: begin
        if (start || pend_q) begin
          state_d = RD_ID;
          pend_d  = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b0;
          idm_d   = 1'b0;
          tsm_d   = 1'b0;
          tmo_d   = 1'b0;
          id_d    = '0;
          ts_d    = '0;
        end
      end
      RD_ID, RD_TS: begin
        // Completion takes priority over an expiring timeout.
        if (!avm.avm_waitrequest) begin
          cnt_d = '0;
          if (state_q == RD_ID) begin
            id_d    = avm.avm_readdata;
            idm_d   = (avm.avm_readdata == EXPECTED_ID);
            state_d = RD_TS;
          end else begin
            ts_d    = avm.avm_readdata;
            tsm_d   = (avm.avm_readdata == EXPECTED_TIMESTAMP);
            state_d = FINISH;
          end
        end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          tmo_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (start) pend_d = 1'b1;   // honoured from IDLE next cycle
      end
      default: state_d = IDLE;
    endcase

    if (state_d == FINISH) done_d = 1'b1;

    // Bus strobes are registered from the next state so they stay flat while
    // stalled and read stays high across the RD_ID->RD_TS hand-over.
    read_d = (state_d == RD_ID) || (state_d == RD_TS);
    addr_d = (state_d == RD_TS);
    busy_d = read_d;
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_match        = idm_q;
  assign ts_match        = tsm_q;
  assign timeout         = tmo_q;
  assign id_value        = id_q;
  assign ts_value        = ts_q;

endmodule
